// File: rtl/prod_acc_norm.sv
// rtl/prod_acc_norm.sv - product accumulator with rounded, saturated 8-bit normalization
// Sums up to MAX_TERMS unsigned products per group, then presents one pixel until handshaken.
module prod_acc_norm #(
    parameter int SHIFT     = 8,
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 28
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [23:0] prod_in,
    input  logic        prod_valid,
    input  logic        prod_last,
    output logic        prod_ready,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        sat_flag,
    output logic        ovf_err
);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    localparam int            CW   = $clog2(MAX_TERMS + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_TERMS);
    localparam int            RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RSH) : '0;

    logic [0:0]      state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]   cnt;

    logic             beat;
    logic             full;
    logic [ACC_W-1:0] sum_next;
    logic [ACC_W:0]   rnd_sum;
    logic [ACC_W:0]   shifted;
    logic             sat_next;
    logic [7:0]       pix_next;

    assign prod_ready = (state == ST_ACC);
    assign pix_valid  = (state == ST_OUT);
    assign beat       = prod_valid & prod_ready;
    assign full       = (cnt == CMAX);

    // Beats past the term limit are dropped from the sum; only the error flag records them.
    assign sum_next = full ? acc : acc + {{(ACC_W - 24){1'b0}}, prod_in};
    assign rnd_sum  = {1'b0, sum_next} + RND;
    assign shifted  = rnd_sum >> SHIFT;
    assign sat_next = |shifted[ACC_W:8];
    assign pix_next = sat_next ? 8'hFF : shifted[7:0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_ACC;
            acc      <= '0;
            cnt      <= '0;
            pix_out  <= '0;
            sat_flag <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat) begin
                        acc <= sum_next;
                        if (full) begin
                            ovf_err <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                        if (prod_last) begin
                            state    <= ST_OUT;
                            pix_out  <= pix_next;
                            sat_flag <= sat_next;
                        end
                    end
                end
                ST_OUT: begin
                    if (pix_ready) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_acc_norm.sv
// tb/tb_prod_acc_norm.sv - self-checking bench for prod_acc_norm
// Directed table, reset/backpressure sequences, then random groups against a sum-and-round model.
module tb_prod_acc_norm;

    localparam int SHIFT     = 8;
    localparam int MAX_TERMS = 16;
    localparam int ACC_W     = 28;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] prod_in;
    logic        prod_valid;
    logic        prod_last;
    logic        prod_ready;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready;
    logic        sat_flag;
    logic        ovf_err;

    prod_acc_norm #(.SHIFT(SHIFT), .MAX_TERMS(MAX_TERMS), .ACC_W(ACC_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .sat_flag   (sat_flag),
        .ovf_err    (ovf_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          n;
        logic [23:0] first;
        logic [23:0] rest;
        logic [23:0] lastv;
        int          exp_pix;
        bit          exp_sat;
        bit          exp_ovf;
    } vec_t;

    vec_t        tbl[6];
    logic [23:0] gq[$];
    int          total = 0;
    int          bad   = 0;
    bit          ovf_model = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: the first MAX_TERMS beats are summed, rounded half-up, shifted and clipped.
    task automatic model(output int pix, output bit sat);
        longint sum = 0;
        longint r;
        for (int i = 0; i < gq.size() && i < MAX_TERMS; i++) sum += longint'(gq[i]);
        r   = (sum + ((SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0)) >> SHIFT;
        sat = (r > 255);
        pix = sat ? 255 : int'(r);
    endtask

    task automatic run_q(input string tag, input int exp_pix, input bit exp_sat,
                         input bit exp_ovf, input int idle_max, input int wait_cyc);
        for (int i = 0; i < gq.size(); i++) begin
            int idle;
            idle = (idle_max > 0) ? int'($urandom_range(0, idle_max)) : 0;
            repeat (idle) begin
                prod_valid = 1'b0;
                prod_in    = 24'($urandom);
                prod_last  = 1'($urandom);
                @(negedge sys_clk);
            end
            if (i == 0) chk({tag, ".ready_in"}, prod_ready, 1);
            prod_valid = 1'b1;
            prod_in    = gq[i];
            prod_last  = (i == gq.size() - 1);
            @(negedge sys_clk);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        chk({tag, ".latency_valid"}, pix_valid, 1);
        chk({tag, ".ready_low"}, prod_ready, 0);
        chk({tag, ".pix"}, pix_out, exp_pix);
        chk({tag, ".sat"}, sat_flag, exp_sat);
        chk({tag, ".ovf"}, ovf_err, exp_ovf);
        for (int k = 0; k < wait_cyc; k++) begin
            pix_ready  = 1'b0;
            prod_valid = 1'($urandom);
            prod_in    = 24'($urandom);
            prod_last  = 1'($urandom);
            @(negedge sys_clk);
            chk({tag, ".hold_valid"}, pix_valid, 1);
            chk({tag, ".hold_pix"}, pix_out, exp_pix);
            chk({tag, ".hold_sat"}, sat_flag, exp_sat);
            chk({tag, ".hold_ready"}, prod_ready, 0);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        pix_ready  = 1'b1;
        @(negedge sys_clk);
        chk({tag, ".done_valid"}, pix_valid, 0);
        chk({tag, ".done_ready"}, prod_ready, 1);
        pix_ready = 1'($urandom);
    endtask

    initial begin
        tbl[0] = '{1,  24'd0,      24'd0,      24'd384,    2,   1'b0, 1'b0};
        tbl[1] = '{2,  24'd25600,  24'd0,      24'd25727,  200, 1'b0, 1'b0};
        tbl[2] = '{2,  24'd25600,  24'd0,      24'd25728,  201, 1'b0, 1'b0};
        tbl[3] = '{3,  24'h00FF00, 24'h00FF00, 24'h00FF00, 255, 1'b1, 1'b0};
        tbl[4] = '{17, 24'd256,    24'd256,    24'd256,    16,  1'b0, 1'b1};
        tbl[5] = '{1,  24'd0,      24'd0,      24'd512,    2,   1'b0, 1'b1};

        sys_rst    = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        pix_ready  = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst.prod_ready", prod_ready, 1);
        chk("rst.pix_valid", pix_valid, 0);
        chk("rst.pix_out", pix_out, 0);
        chk("rst.sat_flag", sat_flag, 0);
        chk("rst.ovf_err", ovf_err, 0);

        for (int t = 0; t < 6; t++) begin
            gq.delete();
            for (int i = 0; i < tbl[t].n; i++) begin
                if (i == tbl[t].n - 1) gq.push_back(tbl[t].lastv);
                else if (i == 0)       gq.push_back(tbl[t].first);
                else                   gq.push_back(tbl[t].rest);
            end
            run_q($sformatf("vec%0d", t), tbl[t].exp_pix, tbl[t].exp_sat, tbl[t].exp_ovf, 0, 0);
        end

        // Backpressure with garbage beats offered while the pixel is held.
        gq.delete();
        gq.push_back(24'd1000);
        run_q("bp", 4, 1'b0, 1'b1, 0, 5);
        gq.delete();
        gq.push_back(24'd512);
        run_q("bp_after", 2, 1'b0, 1'b1, 0, 0);

        // Reset mid-group, with a last beat presented during the reset cycle.
        pix_ready  = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 24'hFFFFFF;
        prod_last  = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst   = 1'b1;
        prod_last = 1'b1;
        @(negedge sys_clk);
        sys_rst    = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        chk("midrst.pix_valid", pix_valid, 0);
        chk("midrst.ovf_err", ovf_err, 0);
        gq.delete();
        gq.push_back(24'd512);
        run_q("midrst", 2, 1'b0, 1'b0, 0, 0);

        for (int g = 0; g < 40; g++) begin
            int n;
            int mode;
            int epix;
            bit esat;
            n    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 18))
                                               : int'($urandom_range(1, 16));
            mode = int'($urandom_range(0, 2));
            gq.delete();
            for (int i = 0; i < n; i++) begin
                logic [23:0] v;
                v = 24'($urandom);
                if (mode == 1) v = v & 24'h00FFFF;
                if (mode == 2) v = v & 24'h000FFF;
                gq.push_back(v);
            end
            model(epix, esat);
            if (n > MAX_TERMS) ovf_model = 1'b1;
            run_q($sformatf("rnd%0d", g), epix, esat, ovf_model, 2, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prod_acc_norm.md
PROD_ACC_NORM -- requirements
Module: prod_acc_norm

Interface
REQ-001 Parameter SHIFT, default 8, is the right-shift applied to the accumulated sum; legal range 0..16.
REQ-002 Parameter MAX_TERMS, default 16, is the maximum number of products per group that are summed.
REQ-003 Parameter ACC_W, default 28, is the accumulator width; ACC_W SHALL be at least 24+clog2(MAX_TERMS).
REQ-004 sys_clk  in  1  rising-edge clock for all state.
REQ-005 sys_rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 prod_in  in  24  unsigned product from the 16x8 unsigned multiplier output.
REQ-007 prod_valid  in  1  prod_in is valid this cycle.
REQ-008 prod_last  in  1  qualifies prod_valid: this beat closes the group.
REQ-009 prod_ready  out  1  block accepts a product beat this cycle.
REQ-010 pix_out  out  8  normalized, rounded, saturated result.
REQ-011 pix_valid  out  1  pix_out is valid.
REQ-012 pix_ready  in  1  downstream accepts pix_out.
REQ-013 sat_flag  out  1  pix_out was clipped to 255; valid while pix_valid=1.
REQ-014 ovf_err  out  1  sticky: a group contained more than MAX_TERMS beats.

Function
REQ-015 A beat SHALL be accepted only when prod_valid=1 and prod_ready=1; prod_in and prod_last are ignored in all other cycles.
REQ-016 The state machine SHALL have two states: ACC, with prod_ready=1 and pix_valid=0, and OUT, with prod_ready=0 and pix_valid=1.
REQ-017 In ACC, each accepted beat SHALL add zero-extended prod_in to the accumulator, and the term counter SHALL increment, saturating at MAX_TERMS.
REQ-018 When the counter already equals MAX_TERMS, an accepted beat SHALL leave the accumulator unchanged and set ovf_err=1 on the next edge.
REQ-019 An accepted beat with prod_last=1 SHALL move the state to OUT on the next edge, which includes that beat's sum where REQ-018 permits it.
REQ-020 On that same edge, pix_out SHALL be registered as min(255, (sum + 2^(SHIFT-1)) >> SHIFT), with no rounding term when SHIFT=0, and sat_flag SHALL be set when the clip applies.
REQ-021 Latency: pix_valid=1 in the cycle immediately after the cycle in which the last beat was accepted.
REQ-022 The rounding add SHALL be computed ACC_W+1 bits wide so that it cannot wrap.
REQ-023 In OUT, pix_out and sat_flag SHALL stay stable until pix_valid=1 and pix_ready=1.
REQ-024 On that output handshake, the next edge SHALL clear the accumulator and counter, set pix_valid=0, and return the state to ACC, giving prod_ready=1 in the following cycle.
REQ-025 Throughput: at most one group per (terms+1) cycles; there is exactly one bubble per group when pix_ready=1.
REQ-026 A group of a single beat with prod_last=1 SHALL be legal and SHALL produce the rounded result of prod_in alone.
REQ-027 pix_ready SHALL have no effect in ACC.
REQ-028 ovf_err SHALL be cleared only by sys_rst.

Reset
REQ-029 While sys_rst=1 at a clock edge, the state SHALL go to ACC, the accumulator and counter to 0, pix_out to 0, pix_valid to 0, sat_flag to 0, ovf_err to 0, and prod_ready to 1 after the edge.
REQ-030 Reset asserted in the middle of a group SHALL discard the partial sum; a beat presented in the same cycle as sys_rst=1 SHALL be dropped.

Verification
REQ-031 Single beat: prod_in=384 with last, SHIFT=8 -> pix_out=2, sat_flag=0, pix_valid in the next cycle.
REQ-032 Rounding: beats 25600, then 25727 with last -> sum=51327, pix_out=200; a second group with beats 25600, then 25728 with last -> pix_out=201.
REQ-033 Saturation: three beats of 0x00FF00, last on the third -> sum=195840, pix_out=255, sat_flag=1.
REQ-034 Backpressure: hold pix_ready=0 for 5 cycles in OUT -> pix_out stable and prod_ready=0 throughout; then pix_ready=1 -> pix_valid=0 and prod_ready=1 on the next cycle.
REQ-035 Term overflow: 17 beats of 256, last on the 17th -> ovf_err=1, pix_out=16; ovf_err remains 1 across a following clean group.
REQ-036 Reset mid-group: accept two beats of 0xFFFFFF, pulse sys_rst, then one beat of 512 with last -> pix_out=2, all flags 0.
